// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the bit-serial adder.
// Holds the FSM state encodings and the bit-counter width computation.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // Counter must hold values 0..w-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/Fulladder.sv
// Fulladder: single-bit full adder cell, the only combinational arithmetic
// in the serial adder.
module Fulladder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   // Sum and carry of one bit position.
   always_comb begin
      S    = A ^ B ^ Cin;
      Cout = (A & B) | (A & Cin) | (B & Cin);
   end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around one Fulladder cell.
// An operation is framed by start (sampled in IDLE) and a one-cycle done
// pulse. Optional macro SERIAL_ADDER_SUB_EN adds the sub port: B is stored
// inverted and the carry seeded with 1 so the result is A-B.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s;
   logic             fa_cout;
   logic             last_bit;
   logic [WIDTH-1:0] shifted;

   // One adder cell fed from the operand LSBs and the carry flop.
   Fulladder u_fa (
      .A    (a_q[0]),
      .B    (b_q[0]),
      .Cin  (carry_q),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   assign last_bit = (cnt_q == CW'(WIDTH - 1));
   // New sum bit enters at the top; after WIDTH-1 shifts the low bits are in place.
   assign shifted  = {fa_s, res_q};

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)    state_d = ST_SHIFT;
         ST_SHIFT: if (last_bit) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the registered state only.
   always_comb begin
      busy = (state_q != ST_IDLE);
      done = (state_q == ST_DONE);
   end

   // Datapath next values: load on accept, shift one bit per SHIFT cycle,
   // publish the result on the final shift edge only.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d   = a;
               cnt_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = b;
               carry_d = cin;
`endif
            end
         end
         ST_SHIFT: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = shifted[WIDTH-1:1];
            carry_d = fa_cout;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d  = shifted;
               cout_d = fa_cout;
               // carry_q here is the carry into the MSB.
               ovf_d  = carry_q ^ fa_cout;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed test of serial_adder at WIDTH=8.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic       sub = 1'b0;
`endif
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;
   logic       ovf;

   int checks = 0;
   int failures = 0;
   int done_cnt;

   serial_adder #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One full add: accept, watch latency, check the published result.
   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ts, input logic [7:0] esum,
                        input logic ecout, input logic eovf, input logic [7:0] prev_sum);
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub = ts;
`else
      if (ts) $display("note: %s requests sub in an add-only build", tag);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_busy_e0"}, busy, 1);
      check({tag, "_done_e0"}, done, 0);
      for (int i = 1; i < 8; i++) begin
         @(posedge clk); #1;
         check({tag, "_done_early"}, done, 0);
         if (i == 4) check({tag, "_sum_hold"}, sum, prev_sum);
      end
      @(posedge clk); #1;
      check({tag, "_done"}, done, 1);
      check({tag, "_busy_done"}, busy, 1);
      check({tag, "_sum"}, sum, esum);
      check({tag, "_cout"}, cout, ecout);
      check({tag, "_ovf"}, ovf, eovf);
      @(posedge clk); #1;
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_done_end"}, done, 0);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
   endtask

   initial begin
      // Reset state.
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", busy, 0);

      do_op("add_3c_42", 8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00);
      do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7E);
      do_op("add_cin",   8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h00);
      do_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h01);
      do_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h80);

      // start held high: back-to-back ops, operand change while busy ignored.
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      check("held_busy_e0", busy, 1);
      done_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (done) done_cnt++;
         if (k == 3) a = 8'h55;
         if (k == 8) begin
            check("held_done1", done, 1);
            check("held_sum1", sum, 8'h30);
         end
         if (k == 9)  check("held_idle_busy", busy, 0);
         if (k == 10) check("held_accept2", busy, 1);
         if (k == 11) start = 1'b0;
         if (k == 12) check("held_sum_hold", sum, 8'h30);
         if (k == 18) begin
            check("held_done2", done, 1);
            check("held_sum2", sum, 8'h75);
         end
      end
      check("held_done_pulses", done_cnt, 2);
      check("held_final_busy", busy, 0);

      // Asynchronous reset mid-operation.
      @(negedge clk);
      a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
      end
      check("mid_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_sum", sum, 0);
      check("mid_rst_cout", cout, 0);
      check("mid_rst_ovf", ovf, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", busy, 0);
      check("post_rst_sum", sum, 0);
      do_op("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00);

`ifdef SERIAL_ADDER_SUB_EN
      do_op("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h02);
      do_op("sub_09_03", 8'h09, 8'h03, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 8'hFE);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
